fetch_unit: RTL and testbench

//   Instruction-fetch stage that directly feeds the F/D pipeline register.
//   - Owns the PC and issues word requests to a variable-latency instruction memory.
//   - Presents {f_currPC, f_instruction, f_valid} to the F/D register, which samples them every clock.
//   - Holds the presented instruction while the hazard unit stalls.
//   - On a taken branch/jump redirect: discards wrong-path work and raises flush (drives F/D deactivate).

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding word requests to a
// variable-latency instruction memory and presents a single slot to the F/D register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] f_currPC,
  output logic [31:0] f_instruction,
  output logic        f_valid,
  output logic        flush
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_instr_q, slot_instr_d;
  logic        slot_valid_q, slot_valid_d;

  assign imem_addr     = pc_q;
  assign flush         = redirect;
  assign f_currPC      = slot_pc_q;
  assign f_instruction = slot_instr_q;
  assign f_valid       = slot_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    slot_valid_d = slot_valid_q;
    imem_req     = ((state_q == StReq) || ((state_q == StHold) && !stall)) && !redirect;

    if (redirect) begin
      // Redirect beats stall and ack; an un-acked outstanding request must be drained.
      pc_d         = redirect_pc & ~32'd3;
      slot_pc_d    = '0;
      slot_instr_d = '0;
      slot_valid_d = 1'b0;
      if (((state_q == StWait) || (state_q == StDrain)) && !imem_ack) begin
        state_d = StDrain;
      end else begin
        state_d = StReq;
      end
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem_req) state_d = StWait;
        end
        StWait: begin
          if (imem_ack) begin
            slot_pc_d    = pc_q;
            slot_instr_d = imem_rdata;
            slot_valid_d = 1'b1;
            pc_d         = pc_q + 32'(PC_INC);
            state_d      = StHold;
          end
        end
        StHold: begin
          // Slot consumed by F/D and the next request issued on the same edge.
          if (!stall) begin
            slot_pc_d    = '0;
            slot_instr_d = '0;
            slot_valid_d = 1'b0;
            state_d      = StWait;
          end
        end
        StDrain: begin
          if (imem_ack) state_d = StReq;
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      slot_pc_q    <= '0;
      slot_instr_q <= '0;
      slot_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
      slot_valid_q <= slot_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory responder feeds the main DUT,
// and a second instance with RESET_PC=FFFF_FFFC checks PC wrap.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] f_currPC;
  logic [31:0] f_instruction;
  logic        f_valid;
  logic        flush;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_currPC;
  logic [31:0] w_instr;
  logic        w_valid;
  logic        w_flush;

  int          passes = 0;
  int          total  = 0;
  int          lat    = 1;
  int          cnt;
  logic [31:0] mem_addr;

  always #5 Clk = ~Clk;

  fetch_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .f_currPC     (f_currPC),
    .f_instruction(f_instruction),
    .f_valid      (f_valid),
    .flush        (flush)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk          (Clk),
    .Reset        (Reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_rdata   (32'h0000_0013),
    .imem_ack     (w_ack),
    .f_currPC     (w_currPC),
    .f_instruction(w_instr),
    .f_valid      (w_valid),
    .flush        (w_flush)
  );

  // Memory responder: ack is high during the lat-th cycle after the accepting edge.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt      <= 0;
      mem_addr <= '0;
    end else if (imem_req) begin
      cnt      <= lat;
      mem_addr <= imem_addr;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end
  assign imem_ack   = (cnt == 1);
  assign imem_rdata = (mem_addr == 32'h0) ? 32'h2008_0005 : (32'hC0DE_0000 | {16'h0, mem_addr[15:0]});

  always @(posedge Clk or posedge Reset) begin
    if (Reset) w_ack <= 1'b0;
    else       w_ack <= w_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    chk("rst_valid", 32'(f_valid), 32'd0);
    chk("rst_instr", f_instruction, 32'h0);
    chk("rst_currpc", f_currPC, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    // 1: first fetch with a 1-cycle memory
    Reset = 1'b0;
    #1;
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t5_addr0", w_addr, 32'hFFFF_FFFC);
    tick();
    chk("t1_wait_req", 32'(imem_req), 32'd0);
    chk("t1_wait_valid", 32'(f_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(f_valid), 32'd1);
    chk("t1_instr", f_instruction, 32'h2008_0005);
    chk("t1_currpc", f_currPC, 32'h0);
    chk("t1_next_req", 32'(imem_req), 32'd1);
    chk("t1_next_addr", imem_addr, 32'h4);
    chk("t5_addr1", w_addr, 32'h0);
    chk("t5_currpc", w_currPC, 32'hFFFF_FFFC);
    tick();
    chk("thru_valid0", 32'(f_valid), 32'd0);
    chk("thru_instr0", f_instruction, 32'h0);
    tick();
    chk("thru_valid1", 32'(f_valid), 32'd1);
    chk("thru_currpc", f_currPC, 32'h4);
    chk("thru_instr1", f_instruction, 32'hC0DE_0004);
    tick();
    tick();

    // 2: stall holds the slot at PC 0x8
    chk("t2_currpc", f_currPC, 32'h8);
    stall = 1'b1;
    #1;
    chk("t2_req_stalled", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_valid", 32'(f_valid), 32'd1);
      chk("t2_hold_currpc", f_currPC, 32'h8);
      chk("t2_hold_instr", f_instruction, 32'hC0DE_0008);
      chk("t2_hold_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    #1;
    chk("t2_release_req", 32'(imem_req), 32'd1);
    chk("t2_release_addr", imem_addr, 32'hC);
    tick();
    chk("t2_cleared_valid", 32'(f_valid), 32'd0);
    chk("t2_cleared_instr", f_instruction, 32'h0);
    tick();
    chk("t2_next_currpc", f_currPC, 32'hC);

    // 3: 3-cycle memory, redirect in the first WAIT cycle
    lat = 3;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    #1;
    chk("t3_flush", 32'(flush), 32'd1);
    chk("t3_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("t3_flush_off", 32'(flush), 32'd0);
    chk("t3_drain_req", 32'(imem_req), 32'd0);
    chk("t3_drain_addr", imem_addr, 32'h40);
    tick();
    chk("t3_drain_valid", 32'(f_valid), 32'd0);
    tick();
    chk("t3_late_ack_valid", 32'(f_valid), 32'd0);
    chk("t3_req_after", 32'(imem_req), 32'd1);
    chk("t3_addr_after", imem_addr, 32'h40);

    // 4: redirect coincident with ack
    lat = 1;
    tick();
    chk("t4_ack", 32'(imem_ack), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    #1;
    chk("t4_valid", 32'(f_valid), 32'd0);
    chk("t4_instr", f_instruction, 32'h0);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h40);
    tick();
    tick();
    chk("t4_refetch_valid", 32'(f_valid), 32'd1);
    chk("t4_refetch_currpc", f_currPC, 32'h40);
    chk("t4_refetch_instr", f_instruction, 32'hC0DE_0040);

    // 6: reset asserted mid-WAIT
    lat = 3;
    tick();
    Reset = 1'b1;
    #1;
    chk("t6_valid", 32'(f_valid), 32'd0);
    chk("t6_instr", f_instruction, 32'h0);
    chk("t6_addr", imem_addr, 32'h0);
    tick();
    Reset = 1'b0;
    lat   = 1;
    #1;
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_req_addr", imem_addr, 32'h0);
    tick();
    tick();
    chk("t6_refetch_valid", 32'(f_valid), 32'd1);
    chk("t6_refetch_instr", f_instruction, 32'h2008_0005);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
